wddl_dec_rx: RTL and testbench

- Sequenced decoder at the output end of a WDDL dual-rail datapath.
- Drives the precharge control into the WDDL logic cloud, for example chains of dual-rail XOR stages. It checks the spacer (00) during precharge and waits for evaluation to settle.
- It then samples the dual-rail result, checks every bit is a valid codeword (01/10), and delivers single-rail data downstream over a valid/ready handshake.

---
 rtl/wddl_pkg.sv | 25 ++
 rtl/wddl_cw_chk.sv | 25 ++
 rtl/wddl_dec_rx.sv | 146 ++++++++++++++
 tb/tb_wddl_dec_rx.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/wddl_pkg.sv
// Shared definitions for WDDL dual-rail receivers: FSM encoding, spacer
// codeword, error-counter width and a saturating-add helper.
package wddl_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_PRE  = 2'd1,
      ST_EVAL = 2'd2,
      ST_HOLD = 2'd3
   } state_t;

   // {p, n} of a dual-rail bit in precharge
   localparam logic [1:0] SPACER = 2'b00;

   localparam int unsigned ERR_CNT_W = 8;

   // Add a small increment and clamp at all-ones
   function automatic logic [ERR_CNT_W-1:0] sat_add(input logic [ERR_CNT_W-1:0] a,
                                                    input logic [1:0]           inc);
      logic [ERR_CNT_W:0] sum;
      sum = {1'b0, a} + {{(ERR_CNT_W-1){1'b0}}, inc};
      return sum[ERR_CNT_W] ? '1 : sum[ERR_CNT_W-1:0];
   endfunction

endpackage

// File: rtl/wddl_cw_chk.sv
// Combinational per-bit classifier for WIDTH dual-rail pairs.
// all_spacer  : every pair is 00
// any_invalid : at least one pair is 00 or 11 (not a valid 01/10 codeword)
module wddl_cw_chk
   import wddl_pkg::*;
#(
   parameter int unsigned WIDTH = 1
) (
   input  logic [WIDTH-1:0] p,
   input  logic [WIDTH-1:0] n,
   output logic             all_spacer,
   output logic             any_invalid
);

   // Fold the per-bit classification across all pairs
   always_comb begin
      all_spacer  = 1'b1;
      any_invalid = 1'b0;
      for (int unsigned i = 0; i < WIDTH; i++) begin
         if ({p[i], n[i]} != SPACER) all_spacer = 1'b0;
         if (p[i] == n[i])           any_invalid = 1'b1;
      end
   end

endmodule

// File: rtl/wddl_dec_rx.sv
// Sequenced WDDL dual-rail receiver: drives precharge, checks the spacer at
// the end of precharge, samples and validates the evaluated codewords, and
// hands single-rail data downstream over valid/ready.
// Optional saturating error counter enabled by `define WDDL_DEC_ERRCNT_EN.
module wddl_dec_rx
   import wddl_pkg::*;
#(
   parameter int unsigned WIDTH    = 1,
   parameter int unsigned PRE_CYC  = 1,
   parameter int unsigned EVAL_CYC = 2,
   parameter int unsigned PH_CNT_W = 4
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 en_in,
   input  logic [WIDTH-1:0]     d_p_in,
   input  logic [WIDTH-1:0]     d_n_in,
   output logic                 pre_out,
   output logic [WIDTH-1:0]     d_out,
   output logic                 valid_out,
   input  logic                 ready_in,
   output logic                 spc_err_out,
   output logic                 cw_err_out,
   input  logic                 err_clr_in,
   output logic [ERR_CNT_W-1:0] err_cnt_out
);

   localparam logic [PH_CNT_W-1:0] PRE_LAST  = PH_CNT_W'(PRE_CYC - 1);
   localparam logic [PH_CNT_W-1:0] EVAL_LAST = PH_CNT_W'(EVAL_CYC - 1);
   localparam logic [PH_CNT_W-1:0] CNT_ONE   = PH_CNT_W'(1);

   state_t              state, state_nxt;
   logic [PH_CNT_W-1:0] cnt, cnt_nxt;
   logic                all_spacer, any_invalid;
   logic                pre_end, eval_end, take;
   logic                spc_evt, cw_evt;

   wddl_cw_chk #(.WIDTH(WIDTH)) u_chk (
      .p           (d_p_in),
      .n           (d_n_in),
      .all_spacer  (all_spacer),
      .any_invalid (any_invalid)
   );

   assign pre_end  = (state == ST_PRE)  && (cnt == PRE_LAST);
   assign eval_end = (state == ST_EVAL) && (cnt == EVAL_LAST);
   assign take     = valid_out & ready_in;
   assign spc_evt  = pre_end & ~all_spacer;
   assign cw_evt   = eval_end & any_invalid;

   // State and phase counter registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_IDLE;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   // Next-state and phase counter sequencing
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      case (state)
         ST_IDLE: begin
            if (en_in) begin
               state_nxt = ST_PRE;
               cnt_nxt   = '0;
            end
         end
         ST_PRE: begin
            if (pre_end) begin
               state_nxt = ST_EVAL;
               cnt_nxt   = '0;
            end else begin
               cnt_nxt = cnt + CNT_ONE;
            end
         end
         ST_EVAL: begin
            if (eval_end) begin
               state_nxt = ST_HOLD;
               cnt_nxt   = '0;
            end else begin
               cnt_nxt = cnt + CNT_ONE;
            end
         end
         ST_HOLD: begin
            cnt_nxt = '0;
            if (take) state_nxt = en_in ? ST_PRE : ST_IDLE;
         end
         default: begin
            state_nxt = ST_IDLE;
            cnt_nxt   = '0;
         end
      endcase
   end

   // Precharge is released only while evaluating
   always_comb begin
      pre_out = (state != ST_EVAL);
   end

   // Output data register and valid flag
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         d_out     <= '0;
         valid_out <= 1'b0;
      end else if (eval_end) begin
         d_out     <= d_p_in;
         valid_out <= 1'b1;
      end else if (take) begin
         valid_out <= 1'b0;
      end
   end

   // Sticky error flags; a new event outranks a simultaneous clear
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         spc_err_out <= 1'b0;
         cw_err_out  <= 1'b0;
      end else begin
         spc_err_out <= spc_evt | (spc_err_out & ~err_clr_in);
         cw_err_out  <= cw_evt  | (cw_err_out  & ~err_clr_in);
      end
   end

`ifdef WDDL_DEC_ERRCNT_EN
   logic [ERR_CNT_W-1:0] err_cnt;

   // Saturating error event counter; clear applies before this cycle's events
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_cnt <= '0;
      end else begin
         err_cnt <= sat_add(err_clr_in ? '0 : err_cnt, {1'b0, spc_evt} + {1'b0, cw_evt});
      end
   end

   assign err_cnt_out = err_cnt;
`else
   assign err_cnt_out = '0;
`endif

endmodule

// File: tb/tb_wddl_dec_rx.sv
// Directed self-checking bench for wddl_dec_rx (WIDTH=4, default phases).
// The WDDL datapath is modelled as a mux: spacer-phase values while pre_out=1,
// evaluate-phase values while pre_out=0.
module tb_wddl_dec_rx;

   localparam int unsigned W = 4;

`ifdef WDDL_DEC_ERRCNT_EN
   localparam bit CNT_ON = 1'b1;
`else
   localparam bit CNT_ON = 1'b0;
`endif

   logic         clk = 1'b0;
   logic         rst_n;
   logic         en_in;
   logic [W-1:0] d_p_in, d_n_in;
   logic         pre_out;
   logic [W-1:0] d_out;
   logic         valid_out;
   logic         ready_in;
   logic         spc_err_out, cw_err_out;
   logic         err_clr_in;
   logic [7:0]   err_cnt_out;

   logic [W-1:0] pre_p, pre_n, ev_p, ev_n;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   assign d_p_in = pre_out ? pre_p : ev_p;
   assign d_n_in = pre_out ? pre_n : ev_n;

   wddl_dec_rx #(.WIDTH(W), .PRE_CYC(1), .EVAL_CYC(2), .PH_CNT_W(4)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .en_in       (en_in),
      .d_p_in      (d_p_in),
      .d_n_in      (d_n_in),
      .pre_out     (pre_out),
      .d_out       (d_out),
      .valid_out   (valid_out),
      .ready_in    (ready_in),
      .spc_err_out (spc_err_out),
      .cw_err_out  (cw_err_out),
      .err_clr_in  (err_clr_in),
      .err_cnt_out (err_cnt_out)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] cnt_exp(input int v);
      return CNT_ON ? 32'(v) : 32'd0;
   endfunction

   initial begin
      int words;
      int cyc;
      rst_n      = 1'b0;
      en_in      = 1'b0;
      ready_in   = 1'b0;
      err_clr_in = 1'b0;
      pre_p = '0; pre_n = '0; ev_p = 4'hA; ev_n = 4'h5;

      // Reset state
      #1;
      check("rst_pre",   pre_out, 1);
      check("rst_valid", valid_out, 0);
      check("rst_dout",  d_out, 0);
      check("rst_spc",   spc_err_out, 0);
      check("rst_cw",    cw_err_out, 0);
      check("rst_cnt",   err_cnt_out, 0);
      tick(); tick();
      rst_n = 1'b1;
      tick();

      // Nominal: IDLE -> PRE -> EVAL -> EVAL -> HOLD, pre_out 1,1,0,0,1
      en_in = 1'b1; ready_in = 1'b1;
      check("nom_idle_pre", pre_out, 1);
      tick(); check("nom_pre_pre", pre_out, 1);
      tick(); check("nom_ev0_pre", pre_out, 0);
      tick(); check("nom_ev1_pre", pre_out, 0);
              check("nom_ev1_valid", valid_out, 0);
      tick(); check("nom_hold_pre", pre_out, 1);
              check("nom_valid", valid_out, 1);
              check("nom_dout", d_out, 4'hA);
              check("nom_spc", spc_err_out, 0);
              check("nom_cw", cw_err_out, 0);
      // Second word back to back, ready held high
      tick(); check("nom2_pre_pre", pre_out, 1);
              check("nom2_valid_drop", valid_out, 0);
      tick(); check("nom2_ev0_pre", pre_out, 0);
      ready_in = 1'b0;
      tick(); check("nom2_ev1_pre", pre_out, 0);
      tick();

      // Backpressure: 5 cycles held, upstream changes are ignored
      ev_p = 4'h3; ev_n = 4'hC; en_in = 1'b0;
      for (int i = 0; i < 5; i++) begin
         check("bp_valid", valid_out, 1);
         check("bp_dout", d_out, 4'hA);
         check("bp_pre", pre_out, 1);
         tick();
      end
      ready_in = 1'b1;
      check("bp_valid6", valid_out, 1);
      tick();
      check("bp_accept", valid_out, 0);
      check("bp_idle_pre", pre_out, 1);
      tick();
      check("bp_stay_idle", pre_out, 1);

      // Spacer fault: bit 2 p=1 during precharge
      pre_p = 4'b0100; ev_p = 4'hA; ev_n = 4'h5;
      en_in = 1'b1;
      tick(); en_in = 1'b0;
      check("spc_before", spc_err_out, 0);
      tick(); pre_p = '0;
      check("spc_flag", spc_err_out, 1);
      check("spc_cnt", err_cnt_out, cnt_exp(1));
      tick(); tick();
      check("spc_valid", valid_out, 1);
      check("spc_dout", d_out, 4'hA);
      check("spc_cw", cw_err_out, 0);
      tick();

      // Codeword fault: p=F n=1 -> bit0 is 11
      ev_p = 4'hF; ev_n = 4'h1;
      en_in = 1'b1;
      tick(); en_in = 1'b0;
      tick(); tick(); tick();
      check("cw_valid", valid_out, 1);
      check("cw_dout", d_out, 4'hF);
      check("cw_flag", cw_err_out, 1);
      check("cw_spc_sticky", spc_err_out, 1);
      check("cw_cnt", err_cnt_out, cnt_exp(2));
      tick();
      err_clr_in = 1'b1;
      tick(); err_clr_in = 1'b0;
      check("clr_spc", spc_err_out, 0);
      check("clr_cw", cw_err_out, 0);
      check("clr_cnt", err_cnt_out, 0);

      // Clear coinciding with a new codeword error: event wins
      pre_p = 4'b0001;
      en_in = 1'b1;
      tick(); en_in = 1'b0;
      tick(); pre_p = '0;
      check("clrev_spc_set", spc_err_out, 1);
      tick(); err_clr_in = 1'b1;
      tick(); err_clr_in = 1'b0;
      check("clrev_spc", spc_err_out, 0);
      check("clrev_cw", cw_err_out, 1);
      check("clrev_cnt", err_cnt_out, cnt_exp(1));
      tick();
      err_clr_in = 1'b1;
      tick(); err_clr_in = 1'b0;

      // Saturation: 300 consecutive invalid words (both rails 1)
      ev_p = 4'hF; ev_n = 4'hF;
      en_in = 1'b1;
      words = 0; cyc = 0;
      while (words < 300 && cyc < 3000) begin
         if (valid_out) begin
            words++;
            if (words == 300) en_in = 1'b0;
         end
         tick();
         cyc++;
      end
      check("sat_words", words, 300);
      check("sat_cnt", err_cnt_out, cnt_exp(255));
      check("sat_cw", cw_err_out, 1);
      check("sat_idle", valid_out, 0);
      tick();

      // Async reset mid-EVAL
      ev_p = 4'hA; ev_n = 4'h5;
      en_in = 1'b1;
      tick(); tick();
      check("ar_in_eval", pre_out, 0);
      #3 rst_n = 1'b0;
      #1;
      check("ar_pre", pre_out, 1);
      check("ar_valid", valid_out, 0);
      check("ar_dout", d_out, 0);
      check("ar_cw", cw_err_out, 0);
      check("ar_cnt", err_cnt_out, 0);
      #2 rst_n = 1'b1;
      tick(); check("ar_pre_ph", pre_out, 1);
      tick(); check("ar_ev0", pre_out, 0);
      tick(); check("ar_ev1", pre_out, 0);
      tick(); check("ar_valid_again", valid_out, 1);
              check("ar_dout_again", d_out, 4'hA);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
